// File: rtl/passcode_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : passcode_access_controller
// Brief    : Arms on a due dose, unlocks the compartment on a passcode pass,
//            and enforces a timed lockout with alarm after repeated failures.
// Revision : 1.0 - initial release
// ============================================================================
module passcode_access_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 1000,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Pass_Fail_In,
    input  logic       Dose_Due,
    input  logic       Dispense_Ack,
    output logic       Unlock_Out,
    output logic       Lockout_Out,
    output logic       Alarm_Out,
    output logic       Missed_Dose,
    output logic [2:0] Attempt_Count,
    output logic [1:0] State_Out
);

    localparam int c_max_cycles = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int c_timer_w    = $clog2(c_max_cycles);

    localparam logic [c_timer_w-1:0] c_unlock_load  = c_timer_w'(UNLOCK_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_lockout_load = c_timer_w'(LOCKOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timer_zero   = '0;
    localparam logic [2:0]           c_max_fails    = 3'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ARMED    = 2'b01,
        S_UNLOCKED = 2'b10,
        S_LOCKOUT  = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_prev;
    logic [c_timer_w-1:0]   r_timer;
    logic [c_timer_w-1:0]   w_timer_nxt;
    logic [2:0]             r_attempts;
    logic [2:0]             w_attempts_nxt;
    logic [2:0]             w_fail_cnt;
    logic                   r_missed;
    logic                   w_missed_nxt;
    logic                   w_pass_evt;
    logic                   w_fail_evt;

    // A result held across many cycles is only an event on its first cycle.
    assign w_pass_evt = (Pass_Fail_In == 2'b01) && (r_prev != 2'b01);
    assign w_fail_evt = (Pass_Fail_In == 2'b10) && (r_prev != 2'b10);
    assign w_fail_cnt = r_attempts + 3'd1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_prev     <= 2'b00;
            r_timer    <= '0;
            r_attempts <= 3'd0;
            r_missed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= Pass_Fail_In;
            r_timer    <= w_timer_nxt;
            r_attempts <= w_attempts_nxt;
            r_missed   <= w_missed_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_attempts_nxt = r_attempts;
        w_missed_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Dose_Due) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_pass_evt) begin
                    w_state_nxt    = S_UNLOCKED;
                    w_attempts_nxt = 3'd0;
                    w_timer_nxt    = c_unlock_load;
                end else if (w_fail_evt) begin
                    w_attempts_nxt = w_fail_cnt;
                    if (w_fail_cnt == c_max_fails) begin
                        w_state_nxt = S_LOCKOUT;
                        w_timer_nxt = c_lockout_load;
                    end
                end else if (!Dose_Due) begin
                    w_state_nxt    = S_IDLE;
                    w_attempts_nxt = 3'd0;
                end
            end
            S_UNLOCKED: begin
                // Acknowledgement takes priority over a coincident timeout.
                if (Dispense_Ack) begin
                    w_state_nxt = S_IDLE;
                end else if (r_timer == c_timer_zero) begin
                    w_state_nxt  = S_IDLE;
                    w_missed_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (r_timer == c_timer_zero) begin
                    w_attempts_nxt = 3'd0;
                    w_state_nxt    = Dose_Due ? S_ARMED : S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Unlock_Out    = (r_state == S_UNLOCKED);
    assign Lockout_Out   = (r_state == S_LOCKOUT);
    assign Alarm_Out     = (r_state == S_LOCKOUT);
    assign Missed_Dose   = r_missed;
    assign Attempt_Count = r_attempts;
    assign State_Out     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_passcode_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_passcode_access_controller
// Brief    : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_passcode_access_controller;

    localparam int MAX_FAILS      = 3;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int LOCKOUT_CYCLES = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [1:0] Pass_Fail_In = 2'b00;
    logic       Dose_Due = 1'b0;
    logic       Dispense_Ack = 1'b0;
    logic       Unlock_Out;
    logic       Lockout_Out;
    logic       Alarm_Out;
    logic       Missed_Dose;
    logic [2:0] Attempt_Count;
    logic [1:0] State_Out;

    int checks = 0;
    int errors = 0;

    passcode_access_controller #(
        .MAX_FAILS      (MAX_FAILS),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Pass_Fail_In  (Pass_Fail_In),
        .Dose_Due      (Dose_Due),
        .Dispense_Ack  (Dispense_Ack),
        .Unlock_Out    (Unlock_Out),
        .Lockout_Out   (Lockout_Out),
        .Alarm_Out     (Alarm_Out),
        .Missed_Dose   (Missed_Dose),
        .Attempt_Count (Attempt_Count),
        .State_Out     (State_Out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 armed, 2 unlocked, 3 lockout; m_left counts cycles left in a window.
    int         m_mode = 0;
    int         m_left = 0;
    int         m_fails = 0;
    logic [1:0] m_prev = 2'b00;
    bit         m_missed = 1'b0;
    bit         m_pe;
    bit         m_fe;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_mode = 0; m_left = 0; m_fails = 0; m_prev = 2'b00; m_missed = 1'b0;
        end else begin
            m_pe = (Pass_Fail_In == 2'b01) && (m_prev != 2'b01);
            m_fe = (Pass_Fail_In == 2'b10) && (m_prev != 2'b10);
            m_missed = 1'b0;
            case (m_mode)
                0: if (Dose_Due) m_mode = 1;
                1: begin
                    if (m_pe) begin
                        m_mode = 2; m_fails = 0; m_left = UNLOCK_CYCLES;
                    end else if (m_fe) begin
                        m_fails++;
                        if (m_fails >= MAX_FAILS) begin
                            m_mode = 3; m_left = LOCKOUT_CYCLES;
                        end
                    end else if (!Dose_Due) begin
                        m_mode = 0; m_fails = 0;
                    end
                end
                2: begin
                    m_left--;
                    if (Dispense_Ack) m_mode = 0;
                    else if (m_left == 0) begin m_mode = 0; m_missed = 1'b1; end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_fails = 0; m_mode = Dose_Due ? 1 : 0; end
                end
            endcase
            m_prev = Pass_Fail_In;
        end
    end

    always @(negedge Clk) begin
        check("cmp_state",   int'(State_Out),     m_mode);
        check("cmp_unlock",  int'(Unlock_Out),    int'(m_mode == 2));
        check("cmp_lockout", int'(Lockout_Out),   int'(m_mode == 3));
        check("cmp_alarm",   int'(Alarm_Out),     int'(m_mode == 3));
        check("cmp_missed",  int'(Missed_Dose),   int'(m_missed));
        check("cmp_attempt", int'(Attempt_Count), m_fails);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic fail_entry();
        Pass_Fail_In = 2'b10; cyc(1);
        Pass_Fail_In = 2'b00; cyc(1);
    endtask

    int n_unlock;
    int n_missed;
    int n_lock;
    int hold;

    initial begin
        // Reset and arm
        cyc(3);
        check("rst_state", int'(State_Out), 0);
        check("rst_unlock", int'(Unlock_Out), 0);
        Rst = 1'b1;
        Dose_Due = 1'b1;
        cyc(1);
        check("arm_state", int'(State_Out), 1);

        // Pass held 5 cycles, ack during unlock cycle 3
        Pass_Fail_In = 2'b01; cyc(1);
        check("pass_unlock", int'(Unlock_Out), 1);
        cyc(2);
        Dispense_Ack = 1'b1; cyc(1);
        Dispense_Ack = 1'b0;
        check("ack_idle", int'(State_Out), 0);
        check("ack_no_missed", int'(Missed_Dose), 0);
        cyc(1);
        check("held_pass_once", int'(State_Out), 1);
        Pass_Fail_In = 2'b00; cyc(1);

        // Missed dose: window length and single pulse
        Pass_Fail_In = 2'b01; cyc(1);
        Pass_Fail_In = 2'b00;
        n_unlock = 0; n_missed = 0;
        repeat (12) begin
            if (Unlock_Out) n_unlock++;
            if (Missed_Dose) n_missed++;
            cyc(1);
        end
        check("unlock_len", n_unlock, UNLOCK_CYCLES);
        check("missed_pulses", n_missed, 1);

        // Ack on the last window cycle suppresses the pulse
        Pass_Fail_In = 2'b01; cyc(1);
        Pass_Fail_In = 2'b00; cyc(7);
        check("last_cycle_unlock", int'(Unlock_Out), 1);
        Dispense_Ack = 1'b1; cyc(1);
        Dispense_Ack = 1'b0;
        check("late_ack_no_missed", int'(Missed_Dose), 0);
        check("late_ack_idle", int'(State_Out), 0);
        cyc(1);

        // Lockout after three fails; pass during lockout ignored
        Pass_Fail_In = 2'b10; cyc(1); check("fail_cnt1", int'(Attempt_Count), 1);
        Pass_Fail_In = 2'b00; cyc(1);
        Pass_Fail_In = 2'b10; cyc(1); check("fail_cnt2", int'(Attempt_Count), 2);
        Pass_Fail_In = 2'b00; cyc(1);
        Pass_Fail_In = 2'b10; cyc(1); check("fail_cnt3", int'(Attempt_Count), 3);
        check("alarm_on", int'(Alarm_Out), 1);
        Pass_Fail_In = 2'b00;
        n_lock = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) Pass_Fail_In = 2'b01;
            if (i == 5) Pass_Fail_In = 2'b00;
            if (Lockout_Out) n_lock++;
            cyc(1);
        end
        check("lockout_len", n_lock, LOCKOUT_CYCLES);
        check("lockout_exit_armed", int'(State_Out), 1);
        check("lockout_exit_cnt", int'(Attempt_Count), 0);

        // Two fails then pass clears count
        fail_entry(); fail_entry();
        Pass_Fail_In = 2'b01; cyc(1);
        check("fail_pass_unlock", int'(Unlock_Out), 1);
        check("fail_pass_cnt", int'(Attempt_Count), 0);
        Pass_Fail_In = 2'b00;
        Dispense_Ack = 1'b1; cyc(1);
        Dispense_Ack = 1'b0; cyc(1);

        // Two fails then disarm
        fail_entry(); fail_entry();
        Dose_Due = 1'b0; cyc(1);
        check("disarm_idle", int'(State_Out), 0);
        check("disarm_cnt", int'(Attempt_Count), 0);
        Dose_Due = 1'b1; cyc(1);

        // Held fail counts once
        Pass_Fail_In = 2'b10; cyc(10);
        check("held_fail_cnt", int'(Attempt_Count), 1);
        Pass_Fail_In = 2'b00; cyc(1);

        // Async reset mid-lockout
        fail_entry();
        Pass_Fail_In = 2'b10; cyc(1);
        Pass_Fail_In = 2'b00;
        check("pre_rst_lock", int'(Lockout_Out), 1);
        cyc(4);
        #3;
        Rst = 1'b0;
        #1;
        check("async_alarm_drop", int'(Alarm_Out), 0);
        check("async_lock_drop", int'(Lockout_Out), 0);
        cyc(2);
        Rst = 1'b1;
        #1;
        check("post_rst_idle", int'(State_Out), 0);
        check("post_rst_cnt", int'(Attempt_Count), 0);
        cyc(1);

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    Pass_Fail_In = 2'b01;
                    2, 3, 4: Pass_Fail_In = 2'b10;
                    5:       Pass_Fail_In = 2'b11;
                    default: Pass_Fail_In = 2'b00;
                endcase
                hold = $urandom_range(1, 4);
            end
            hold--;
            if ($urandom_range(0, 19) == 0) Dose_Due = ~Dose_Due;
            Dispense_Ack = ($urandom_range(0, 9) == 0);
            Rst = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        Rst = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/passcode_access_controller.md
# passcode_access_controller

Downstream stage of the passcode verifier: consumes its 2-bit pass/fail result and decides whether the medicine compartment is unlocked. Arms when the reminder logic flags a dose as due, unlocks for a bounded window on a correct passcode, counts wrong entries, and enforces a timed lockout with an alarm after too many failures. Also reports a missed dose when an unlocked window expires without a dispense acknowledgement.

## Interface

- MAX_FAILS, 3, consecutive failed entries that trigger lockout (legal 2..7)
- UNLOCK_CYCLES, 1000, length of the unlock window in clock cycles (≥2)
- LOCKOUT_CYCLES, 5000, length of the lockout in clock cycles (≥2)

- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-low reset
- Pass_Fail_In  in  2  verifier result: 00 no result, 01 pass, 10 fail, 11 reserved (treated as 00)
- Dose_Due  in  1  level, high while a dose is pending
- Dispense_Ack  in  1  level/pulse, high when the compartment has been opened and the dose taken
- Unlock_Out  out  1  compartment unlock
- Lockout_Out  out  1  high during lockout
- Alarm_Out  out  1  high during lockout
- Missed_Dose  out  1  one-cycle pulse on unlock-window timeout
- Attempt_Count  out  3  failed entries in the current armed session
- State_Out  out  2  00 IDLE, 01 ARMED, 10 UNLOCKED, 11 LOCKOUT

## Operation

- Event detection: Pass_Fail_In registered into prev each cycle; pass_evt = (in==01 && prev!=01); fail_evt = (in==10 && prev!=10). A result held for many cycles counts once. 11 is never an event.
- IDLE: all outputs 0. Dose_Due=1 → ARMED. Events ignored.
- ARMED: pass_evt → UNLOCKED, Attempt_Count←0, timer←UNLOCK_CYCLES-1. fail_evt → Attempt_Count+1; if the new count equals MAX_FAILS → LOCKOUT, timer←LOCKOUT_CYCLES-1, Attempt_Count holds MAX_FAILS. Dose_Due=0 (with no event) → IDLE, Attempt_Count←0. If an event and Dose_Due=0 coincide, the event wins.
- UNLOCKED: Unlock_Out=1. Dispense_Ack=1 → IDLE. Else timer==0 → IDLE with Missed_Dose pulse. Else timer decrements. If ack and timer==0 coincide, ack wins and no pulse. Dose_Due falling has no effect. Events ignored.
- LOCKOUT: Lockout_Out=Alarm_Out=1. Timer decrements; at timer==0, Attempt_Count←0 and next state is ARMED if Dose_Due=1, else IDLE. Events and Dispense_Ack ignored; an entry held across lockout exit does not re-fire because prev tracks it throughout.
- Timer: unsigned, width clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)); never wraps. Loaded only on entry to UNLOCKED/LOCKOUT.
- Attempt_Count saturates at MAX_FAILS and never wraps.

## Timing

- Reset (Rst=0, asynchronous): state IDLE, prev=00, timer=0, Attempt_Count=0, all outputs 0. Reset mid-unlock or mid-lockout drops Unlock_Out/Alarm_Out immediately, without waiting for a clock edge.
- All outputs are registered (Moore, decoded from registered state plus a registered Missed_Dose flop).
- Latency: an event sampled at edge k gives the new state and outputs after edge k. Unlock_Out rises 1 cycle after the first pass sample.
- Unlock window: Unlock_Out is high for exactly UNLOCK_CYCLES cycles absent ack. Lockout: Lockout_Out is high for exactly LOCKOUT_CYCLES cycles.
- Missed_Dose is high for the single cycle after the timeout edge, coincident with the first IDLE cycle.
- Dispense_Ack is acted on in the same edge it is sampled. Unlock_Out falls 1 cycle later.

## Test plan

- Reset and arm: Rst low for 3 cycles, then Dose_Due=1 → all outputs 0 during reset, State_Out=01 one cycle after Dose_Due is sampled.
- Pass and dispense (UNLOCK_CYCLES=8): Pass_Fail_In=01 held 5 cycles → Unlock_Out high from the next cycle, only one event. Dispense_Ack at unlock cycle 3 → State_Out=00, no Missed_Dose.
- Missed dose (UNLOCK_CYCLES=8): pass, no ack → Unlock_Out high for exactly 8 cycles, Missed_Dose high for 1 cycle, then IDLE. Repeat with ack on cycle 8 → no pulse.
- Lockout (MAX_FAILS=3, LOCKOUT_CYCLES=16): three fail entries separated by 00 → Attempt_Count 1,2,3. Lockout_Out/Alarm_Out high for 16 cycles. A pass entry during lockout is ignored. Exit to ARMED with count 0.
- Failure clearing and disarm: two fails, then pass → count 0 and unlocked. Separately, two fails then Dose_Due=0 → IDLE, count 0. A fail held for 10 cycles → count +1 only.
- Async reset mid-lockout: Rst low at lockout cycle 5, between clock edges → Alarm_Out drops immediately. After release → IDLE, count 0.
